// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-NUM_CH packet demultiplexer.
// The destination is chosen on the first beat of each packet and held until
// the last beat. Packets with an out-of-range select are swallowed whole,
// counted, and flagged through a sticky error bit.
module stream_demux #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  output logic [NUM_CH-1:0]       out_last,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic                    busy,
  output logic                    err_sel,
  output logic [7:0]              drop_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t             state;
  logic [SEL_W-1:0]   cur_ch;
  logic [SEL_W-1:0]   hold_ch;
  logic [WIDTH-1:0]   hold_data;
  logic               hold_last;
  logic               full;

  logic [NUM_CH-1:0]  hold_onehot;
  logic               drain;
  logic               accept;
  logic               sel_ok;

  // Decode the held channel so that later indexing never leaves NUM_CH.
  always_comb begin
    hold_onehot = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      hold_onehot[k] = (int'(hold_ch) == k);
    end
  end

  assign drain  = full && ((hold_onehot & out_ready) != '0);
  assign sel_ok = (int'(sel) < NUM_CH);
  assign accept = in_valid && in_ready;
  assign busy   = (state != IDLE) || full;

  // Ready: a dropping packet is always sunk; otherwise room must exist or be freed this cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!rst_n) begin
      in_ready = 1'b0;
    end else if (state == DROP) begin
      in_ready = 1'b1;
    end else begin
      in_ready = !full || drain;
    end
  end

  // Present the held beat only on its own channel slice; all others read zero.
  always_comb begin
    out_data  = '0;
    out_valid = '0;
    out_last  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (full && hold_onehot[k]) begin
        out_data[k*WIDTH +: WIDTH] = hold_data;
        out_valid[k]               = 1'b1;
        out_last[k]                = hold_last;
      end
    end
  end

  // Packet FSM plus holding register; a load in the same edge as a drain keeps full set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_ch    <= '0;
      hold_ch   <= '0;
      hold_data <= '0;
      hold_last <= 1'b0;
      full      <= 1'b0;
      err_sel   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (drain) begin
        full <= 1'b0;
      end
      if (accept) begin
        case (state)
          IDLE: begin
            if (sel_ok) begin
              cur_ch    <= sel;
              hold_ch   <= sel;
              hold_data <= in_data;
              hold_last <= in_last;
              full      <= 1'b1;
              state     <= in_last ? IDLE : ROUTE;
            end else begin
              err_sel <= 1'b1;
              if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
              end
              state <= in_last ? IDLE : DROP;
            end
          end
          ROUTE: begin
            hold_ch   <= cur_ch;
            hold_data <= in_data;
            hold_last <= in_last;
            full      <= 1'b1;
            if (in_last) begin
              state <= IDLE;
            end
          end
          DROP: begin
            if (in_last) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed stimulus with a scoreboard queue; a monitor
// pops expected beats whenever a channel completes a transfer.
module tb_stream_demux;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 3;

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic                    clk;
  logic                    rst_n;
  logic [WIDTH-1:0]        in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_last;
  logic [NUM_CH-1:0]       out_ready;
  logic                    busy;
  logic                    err_sel;
  logic [7:0]              drop_cnt;

  int    assertCount = 0;
  int    failCount   = 0;
  beat_t sb[$];

  stream_demux #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .sel      (sel),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy),
    .err_sel  (err_sel),
    .drop_cnt (drop_cnt)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stuck simulation.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one beat and wait for acceptance; push the expected delivery when routed.
  task automatic applyStimulus(input logic [7:0] d, input logic l, input logic [2:0] s,
                               input int expCh, output int waited);
    beat_t b;
    bit    done;
    done   = 1'b0;
    waited = 0;
    in_data  = d;
    in_last  = l;
    sel      = s;
    in_valid = 1'b1;
    while (!done && waited <= 50) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else waited++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL acceptTimeout: beat 0x%0h not accepted after %0d cycles, expected acceptance", d, waited);
    end else if (expCh >= 0) begin
      b.ch   = expCh;
      b.data = d;
      b.last = l;
      sb.push_back(b);
    end
  endtask

  // Monitor: every completed channel transfer must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("oneHot", 32'($countones(out_valid) <= 1), 32'd1);
      for (int k = 0; k < NUM_CH; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (sb.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL unexpectedBeat: ch %0d data 0x%0h, expected no beat", k, out_data[k*WIDTH +: WIDTH]);
          end else begin
            beat_t e;
            e = sb.pop_front();
            checkOutput("sbChannel", 32'(k), 32'(e.ch));
            checkOutput("sbData", 32'(out_data[k*WIDTH +: WIDTH]), 32'(e.data));
            checkOutput("sbLast", 32'(out_last[k]), 32'(e.last));
          end
        end
      end
    end
  end

  initial begin
    int w;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    in_last   = 1'b0;
    sel       = '0;
    out_ready = 4'hF;

    // Reset held with input valid asserted.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("rstReady", 32'(in_ready), 32'd0);
      checkOutput("rstValid", 32'(out_valid), 32'd0);
      checkOutput("rstDrop", 32'(drop_cnt), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Mid-packet select change is ignored.
    applyStimulus(8'hA1, 1'b0, 3'd2, 2, w);
    checkOutput("midValid1", 32'(out_valid), 32'b0100);
    checkOutput("midLast1", 32'(out_last), 32'b0000);
    applyStimulus(8'hA2, 1'b0, 3'd1, 2, w);
    checkOutput("midValid2", 32'(out_valid), 32'b0100);
    checkOutput("midData2", out_data, 32'h00A2_0000);
    applyStimulus(8'hA3, 1'b1, 3'd1, 2, w);
    checkOutput("midValid3", 32'(out_valid), 32'b0100);
    checkOutput("midLast3", 32'(out_last), 32'b0100);

    // Back-to-back single-beat packets to different channels.
    applyStimulus(8'h11, 1'b1, 3'd0, 0, w);
    checkOutput("b2bValid0", 32'(out_valid), 32'b0001);
    applyStimulus(8'h22, 1'b1, 3'd3, 3, w);
    checkOutput("b2bNoBubble", 32'(w), 32'd0);
    checkOutput("b2bValid3", 32'(out_valid), 32'b1000);
    @(posedge clk);
    #1;
    checkOutput("idleBusy", 32'(busy), 32'd0);

    // Backpressure on channel 1 only.
    out_ready = 4'b1101;
    applyStimulus(8'hB1, 1'b0, 3'd1, 1, w);
    in_data  = 8'hB2;
    in_last  = 1'b0;
    sel      = 3'd0;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("bpReady", 32'(in_ready), 32'd0);
      checkOutput("bpValid", 32'(out_valid), 32'b0010);
      checkOutput("bpData", out_data, 32'h0000_B100);
      checkOutput("bpLast", 32'(out_last), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 4'hF;
    applyStimulus(8'hB2, 1'b0, 3'd0, 1, w);
    applyStimulus(8'hB3, 1'b1, 3'd0, 1, w);
    checkOutput("bpLastBeat", 32'(out_last), 32'b0010);

    // Out-of-range select drops the whole packet.
    applyStimulus(8'hC1, 1'b0, 3'd5, -1, w);
    checkOutput("dropValid1", 32'(out_valid), 32'd0);
    checkOutput("dropErr", 32'(err_sel), 32'd1);
    checkOutput("dropCnt1", 32'(drop_cnt), 32'd1);
    checkOutput("dropBusy", 32'(busy), 32'd1);
    applyStimulus(8'hC2, 1'b1, 3'd0, -1, w);
    checkOutput("dropValid2", 32'(out_valid), 32'd0);
    checkOutput("dropCnt2", 32'(drop_cnt), 32'd1);
    applyStimulus(8'hD0, 1'b1, 3'd0, 0, w);
    checkOutput("afterDropValid", 32'(out_valid), 32'b0001);

    // Drop counter saturation.
    for (int i = 0; i < 255; i++) begin
      applyStimulus(8'(i), 1'b1, 3'd7, -1, w);
      if (i == 252) checkOutput("dropCnt254", 32'(drop_cnt), 32'd254);
    end
    checkOutput("dropCntSat", 32'(drop_cnt), 32'd255);

    // Reset in the middle of a packet.
    applyStimulus(8'hE1, 1'b0, 3'd2, 2, w);
    applyStimulus(8'hE2, 1'b0, 3'd2, -1, w);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hE3;
    @(negedge clk);
    checkOutput("mrReady", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("mrValid", 32'(out_valid), 32'd0);
    checkOutput("mrData", out_data, 32'd0);
    checkOutput("mrLast", 32'(out_last), 32'd0);
    checkOutput("mrBusy", 32'(busy), 32'd0);
    checkOutput("mrErr", 32'(err_sel), 32'd0);
    checkOutput("mrDrop", 32'(drop_cnt), 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    applyStimulus(8'hF1, 1'b0, 3'd1, 1, w);
    checkOutput("postRstValid", 32'(out_valid), 32'b0010);
    applyStimulus(8'hF2, 1'b1, 3'd2, 1, w);
    checkOutput("postRstValid2", 32'(out_valid), 32'b0010);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sbEmpty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
